axis_output_pipe: RTL and testbench
===================================

Name: axis_output_pipe

Overview:
- Return-path counterpart of the conv input pipe.
- Accepts one wide result beat per handshake from the conv engine: COPIES*GROUPS*MEMBERS accumulator words plus tlast.
- Serializes each beat into BEATS narrow AXI-Stream beats toward the output DMA.
- Full throughput: a new wide beat is accepted in the same cycle the last narrow beat of the previous one is consumed.

Parameters:
- COPIES, 2, conv copies per wide beat.
- GROUPS, 1, groups per copy.
- MEMBERS, 12, members per group.
- WORD_WIDTH_ACC, 32, accumulator word width.
- M_OUTPUT_WIDTH_LF, 64, output stream width; must divide S_WIDTH and be a multiple of 8.
- S_WIDTH, COPIES*GROUPS*MEMBERS*WORD_WIDTH_ACC (768 default), derived; wide input width.
- BEATS, S_WIDTH/M_OUTPUT_WIDTH_LF (12 default), derived; narrow beats per wide beat.
- BITS_BEATS, clog2(BEATS) (4), derived; counter width.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- s_axis_tready  out  1  ready to accept a wide beat.
- s_axis_tvalid  in  1  wide beat valid.
- s_axis_tlast  in  1  last wide beat of the output tensor.
- s_axis_tdata  in  S_WIDTH  words, copy-major then group then member; word 0 in LSBs.
- m_axis_tready  in  1  downstream ready.
- m_axis_tvalid  out  1  narrow beat valid.
- m_axis_tlast  out  1  final narrow beat of a wide beat that carried s_axis_tlast.
- m_axis_tdata  out  M_OUTPUT_WIDTH_LF  current slice.
- m_axis_tkeep  out  M_OUTPUT_WIDTH_LF/8  byte enables; all ones whenever m_axis_tvalid.

Behaviour:
- Reset: aresetn low asynchronously clears state to IDLE, beat_cnt=0, m_axis_tvalid=0, m_axis_tlast=0, last_q=0, shift register=0. s_axis_tready is 0 while aresetn is low.
- State IDLE: m_axis_tvalid=0; s_axis_tready=1.
- IDLE to SEND: on s_axis_tvalid && s_axis_tready, on the same edge:
  - shift_reg <= s_axis_tdata; last_q <= s_axis_tlast; beat_cnt <= 0; m_axis_tvalid <= 1.
  - First narrow beat appears the next cycle (latency 1).
- State SEND: m_axis_tdata = shift_reg[M_OUTPUT_WIDTH_LF-1:0]; m_axis_tlast = last_q && (beat_cnt==BEATS-1).
- Narrow handshake: fires when m_axis_tvalid && m_axis_tready.
  - If beat_cnt < BEATS-1: shift_reg shifts right by M_OUTPUT_WIDTH_LF (zero fill); beat_cnt increments.
  - If beat_cnt == BEATS-1 (final slice): s_axis_tready = m_axis_tready, combinational, so the chain is s_axis_tready = (state==IDLE) || (state==SEND && beat_cnt==BEATS-1 && m_axis_tready).
    - If s_axis_tvalid is also high: reload as in IDLE; remain in SEND; no bubble.
    - Otherwise: go to IDLE; m_axis_tvalid <= 0.
- Stall: while m_axis_tready=0, m_axis_tdata, m_axis_tvalid and m_axis_tlast stay stable (AXI rule); s_axis_tready=0 except in IDLE.
- s_axis_tvalid while SEND and not on the final slice is ignored (not ready); the upstream must hold its data.
- tlast of a wide beat is never emitted on a non-final slice; last_q is overwritten on reload.
- BEATS==1: every accepted beat produces exactly one narrow beat, and s_axis_tready = m_axis_tready whenever SEND.
- Mid-operation reset: the partially sent wide beat is discarded; after deassertion the block returns to IDLE with no spurious m_axis_tvalid.

Decomposition:
- params.h provides COPIES, GROUPS, MEMBERS, WORD_WIDTH_ACC and M_OUTPUT_WIDTH_LF as defines; BEATS and BITS_BEATS are localparams.
- Single module; no sub-module warranted. The state/counter/shift register fits in one always block.

Test Plan:
- Single beat, tlast=0, words 0..23 with value=index, m_axis_tready=1 → 12 beats on consecutive cycles starting 1 cycle after accept.
  - Beat k = {word 2k+1, word 2k}, i.e. beat 0 = 0x00000001_00000000.
  - m_axis_tlast never set.
- Same beat with s_axis_tlast=1 → m_axis_tlast high only on beat 11.
- Three back-to-back wide beats, s_axis_tvalid held high, m_axis_tready=1 → 36 consecutive valid cycles with no bubble; s_axis_tready pulses exactly on cycles where beat_cnt=11.
- Random m_axis_tready with 50% duty → data, tlast and tkeep are stable during stalls; word order matches the reference model.
- Assert aresetn=0 at beat 5 of 12 → m_axis_tvalid=0 immediately. After release, s_axis_tready=1 and the next wide beat emits from its own beat 0.
- s_axis_tvalid high during beat 3 of a SEND, with the next wide value differing → not accepted until beat 11 handshake; its contents appear from the following cycle.

Source files
------------

// File: rtl/axis_output_pipe_pkg.sv
// Shared types and defaults for the AXI-Stream output serializer.
// Holds the FSM state encoding, default geometry, and a counter-width helper.
// Imported by axis_output_pipe; there is no logic in this file.
package axis_output_pipe_pkg;

    // Default result geometry: 2 copies x 1 group x 12 members of 32-bit accumulators.
    localparam int DEF_COPIES            = 2;
    localparam int DEF_GROUPS            = 1;
    localparam int DEF_MEMBERS           = 12;
    localparam int DEF_WORD_WIDTH_ACC    = 32;
    localparam int DEF_M_OUTPUT_WIDTH_LF = 64;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // Counter width for the narrow-beat index. The result is never below one bit,
    // so a single-beat configuration still gets a legal vector.
    function automatic int beats_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/axis_output_pipe.sv
// Wide-to-narrow AXI-Stream serializer: one wide result beat in, BEATS narrow beats out.
// Latency: the first narrow beat is valid the cycle after the wide beat is accepted.
// Backpressure: s_axis_tready is high in IDLE, or on the final slice when m_axis_tready is high.
//
// Ports:
//   aclk, aresetn          clock, asynchronous active-low reset
//   s_axis_t{valid,ready,last,data}   wide input (word 0 in the LSBs)
//   m_axis_t{valid,ready,last,data,keep}  narrow output, LSB slice first
module axis_output_pipe
    import axis_output_pipe_pkg::*;
#(
    parameter int COPIES            = DEF_COPIES,
    parameter int GROUPS            = DEF_GROUPS,
    parameter int MEMBERS           = DEF_MEMBERS,
    parameter int WORD_WIDTH_ACC    = DEF_WORD_WIDTH_ACC,
    // Must divide the wide width and be a multiple of 8.
    parameter int M_OUTPUT_WIDTH_LF = DEF_M_OUTPUT_WIDTH_LF
) (
    input  logic                             aclk,
    input  logic                             aresetn,

    output logic                             s_axis_tready,
    input  logic                             s_axis_tvalid,
    input  logic                             s_axis_tlast,
    input  logic [COPIES*GROUPS*MEMBERS*WORD_WIDTH_ACC-1:0] s_axis_tdata,

    input  logic                             m_axis_tready,
    output logic                             m_axis_tvalid,
    output logic                             m_axis_tlast,
    output logic [M_OUTPUT_WIDTH_LF-1:0]     m_axis_tdata,
    output logic [M_OUTPUT_WIDTH_LF/8-1:0]   m_axis_tkeep
);

    localparam int S_WIDTH    = COPIES * GROUPS * MEMBERS * WORD_WIDTH_ACC;
    localparam int BEATS      = S_WIDTH / M_OUTPUT_WIDTH_LF;
    localparam int BITS_BEATS = beats_width(BEATS);
    localparam logic [BITS_BEATS-1:0] LAST_CNT = BITS_BEATS'(BEATS - 1);

    state_t                  state;
    state_t                  state_nxt;
    logic [BITS_BEATS-1:0]   beat_cnt;
    logic [S_WIDTH-1:0]      shift_reg;
    logic                    last_q;

    logic                    on_final;
    logic                    load;
    logic                    fire;

    assign on_final = (beat_cnt == LAST_CNT);

    // Ready is combinational on the final slice so a new wide beat can be taken on the
    // same edge that retires the last narrow beat; that is what removes the bubble.
    // Gated with aresetn so upstream never sees ready while the block is held in reset.
    assign s_axis_tready = aresetn &&
                           ((state == ST_IDLE) ||
                            ((state == ST_SEND) && on_final && m_axis_tready));

    assign load = s_axis_tvalid && s_axis_tready;
    assign fire = m_axis_tvalid && m_axis_tready;

    // Valid is a direct decode of the registered state, so it is glitch-free and
    // drops to zero the instant reset clears the state.
    assign m_axis_tvalid = (state == ST_SEND);
    assign m_axis_tlast  = (state == ST_SEND) && last_q && on_final;
    assign m_axis_tdata  = shift_reg[M_OUTPUT_WIDTH_LF-1:0];
    assign m_axis_tkeep  = '1;

    // ---------------------------------------------------------------- state register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (load) begin
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                // A reload on the final slice keeps us in SEND.
                if (fire && on_final && !load) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- datapath
    // Stalls hold everything: nothing below moves unless a load or a narrow handshake.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            shift_reg <= '0;
            last_q    <= 1'b0;
            beat_cnt  <= '0;
        end else if (load) begin
            shift_reg <= s_axis_tdata;
            last_q    <= s_axis_tlast;
            beat_cnt  <= '0;
        end else if (fire && !on_final) begin
            shift_reg <= shift_reg >> M_OUTPUT_WIDTH_LF;
            beat_cnt  <= beat_cnt + BITS_BEATS'(1);
        end
    end

endmodule

// File: tb/tb_axis_output_pipe.sv
// Self-checking bench for axis_output_pipe with a queue-based reference model.
// Every accepted wide beat is split into expected narrow beats; outputs are checked at negedge.
// Inputs are driven 1 time unit after the rising edge.
module tb_axis_output_pipe;

    localparam int SW = 768;
    localparam int MW = 64;
    localparam int NB = SW / MW;

    logic            aclk = 1'b0;
    logic            aresetn = 1'b0;
    logic            s_axis_tready;
    logic            s_axis_tvalid = 1'b0;
    logic            s_axis_tlast = 1'b0;
    logic [SW-1:0]   s_axis_tdata = '0;
    logic            m_axis_tready = 1'b0;
    logic            m_axis_tvalid;
    logic            m_axis_tlast;
    logic [MW-1:0]   m_axis_tdata;
    logic [MW/8-1:0] m_axis_tkeep;

    axis_output_pipe dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tready (s_axis_tready),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tdata  (s_axis_tdata),
        .m_axis_tready (m_axis_tready),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------ reference model
    typedef struct packed {
        logic [MW-1:0] d;
        logic          l;
    } nb_t;

    nb_t  exp_q[$];
    int   n_popped = 0;
    bit   rand_ready = 1'b0;

    logic          prev_vld = 1'b0;
    logic          prev_rdy = 1'b0;
    logic [MW-1:0] prev_dat = '0;
    logic          prev_last = 1'b0;

    always @(negedge aclk) begin
        nb_t e;
        if (!aresetn) begin
            check("rst_m_vld", 64'(m_axis_tvalid), 64'(0));
            check("rst_s_rdy", 64'(s_axis_tready), 64'(0));
            exp_q.delete();
            prev_vld = 1'b0;
        end else begin
            // Ready iff nothing pending, or only the final slice pending and downstream takes it.
            check("s_rdy", 64'(s_axis_tready),
                  64'((exp_q.size() == 0) || (exp_q.size() == 1 && m_axis_tready)));
            check("m_vld", 64'(m_axis_tvalid), 64'(exp_q.size() != 0));
            if (m_axis_tvalid) begin
                check("tkeep", 64'(m_axis_tkeep), 64'hFF);
                if (prev_vld && !prev_rdy) begin
                    check("stall_dat", prev_dat, m_axis_tdata);
                    check("stall_last", 64'(prev_last), 64'(m_axis_tlast));
                end
                if (m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 64'(1), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check("m_dat", m_axis_tdata, e.d);
                        check("m_last", 64'(m_axis_tlast), 64'(e.l));
                        n_popped++;
                    end
                end
            end
            if (s_axis_tvalid && s_axis_tready) begin
                for (int k = 0; k < NB; k++) begin
                    e.d = s_axis_tdata[k*MW +: MW];
                    e.l = s_axis_tlast && (k == NB - 1);
                    exp_q.push_back(e);
                end
            end
            prev_vld  = m_axis_tvalid;
            prev_rdy  = m_axis_tready;
            prev_dat  = m_axis_tdata;
            prev_last = m_axis_tlast;
        end
    end

    // Random downstream backpressure when enabled.
    always @(posedge aclk) begin
        #1;
        if (rand_ready) m_axis_tready = 1'($urandom_range(0, 1));
    end

    // ------------------------------------------------------------ driver helpers
    // Present a wide beat and hold it until accepted; returns 1 unit after the accepting edge.
    task automatic send_beat(input logic [SW-1:0] d, input logic l);
        bit accepted;
        accepted = 1'b0;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge aclk);
            if (s_axis_tready) begin
                accepted = 1'b1;
                break;
            end
        end
        @(posedge aclk);
        #1;
        s_axis_tvalid = 1'b0;
        if (!accepted) check("accept_timeout", 64'(0), 64'(1));
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge aclk);
            #1;
            if (exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check("drain_timeout", 64'(0), 64'(1));
    endtask

    task automatic wait_popped(input int target);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge aclk);
            #1;
            if (n_popped >= target) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check("pop_timeout", 64'(0), 64'(1));
    endtask

    function automatic logic [SW-1:0] rand_wide();
        logic [SW-1:0] d;
        for (int w = 0; w < SW / 32; w++) d[w*32 +: 32] = $urandom;
        return d;
    endfunction

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    // ------------------------------------------------------------ stimulus
    initial begin
        logic [SW-1:0] idx_d;
        logic [SW-1:0] b_d;
        int base;

        for (int w = 0; w < SW / 32; w++) idx_d[w*32 +: 32] = 32'(w);

        // Reset state
        repeat (3) @(posedge aclk);
        #1;
        check("reset_m_vld", 64'(m_axis_tvalid), 64'(0));
        check("reset_m_last", 64'(m_axis_tlast), 64'(0));
        check("reset_s_rdy", 64'(s_axis_tready), 64'(0));
        aresetn = 1'b1;
        #1;
        check("post_reset_s_rdy", 64'(s_axis_tready), 64'(1));
        m_axis_tready = 1'b1;

        // Index-valued words, no tlast; first slice one cycle after accept
        send_beat(idx_d, 1'b0);
        check("lat1_vld", 64'(m_axis_tvalid), 64'(1));
        check("beat0_dat", m_axis_tdata, 64'h00000001_00000000);
        wait_drain();

        // Same beat with tlast: only the final slice carries it
        send_beat(idx_d, 1'b1);
        wait_drain();

        // Three back-to-back wide beats with no bubble
        send_beat(rand_wide(), 1'b0);
        send_beat(rand_wide(), 1'b0);
        send_beat(rand_wide(), 1'b1);
        wait_drain();

        // Random backpressure and random gaps
        rand_ready = 1'b1;
        for (int n = 0; n < 12; n++) begin
            send_beat(rand_wide(), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) @(posedge aclk);
            #1;
        end
        wait_drain();
        rand_ready = 1'b0;
        @(posedge aclk);
        #1;
        m_axis_tready = 1'b1;

        // Mid-operation reset after five slices
        base = n_popped;
        send_beat(rand_wide(), 1'b1);
        wait_popped(base + 5);
        aresetn = 1'b0;
        #1;
        check("midrst_m_vld", 64'(m_axis_tvalid), 64'(0));
        check("midrst_m_last", 64'(m_axis_tlast), 64'(0));
        check("midrst_s_rdy", 64'(s_axis_tready), 64'(0));
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        #1;
        check("rel_s_rdy", 64'(s_axis_tready), 64'(1));
        check("rel_m_vld", 64'(m_axis_tvalid), 64'(0));
        b_d = rand_wide();
        send_beat(b_d, 1'b0);
        check("rel_beat0", m_axis_tdata, b_d[MW-1:0]);
        wait_drain();

        // Next beat offered during slice 3: held off until the final slice handshake
        base = n_popped;
        send_beat(idx_d, 1'b0);
        wait_popped(base + 3);
        b_d = rand_wide();
        b_d[MW-1:0] = ~idx_d[MW-1:0];
        send_beat(b_d, 1'b1);
        check("late_accept_pt", 64'(n_popped), 64'(base + NB));
        check("late_beat0", m_axis_tdata, b_d[MW-1:0]);
        check("late_vld", 64'(m_axis_tvalid), 64'(1));
        wait_drain();

        repeat (3) @(posedge aclk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
